// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - reset sequencer lock/button inputs and reset-tree outputs
// master drives the PLL lock and button, slave is the sequencer itself.
interface rst_sequencer_if;
   logic       pll_locked;
   logic       ext_rst;
   logic       rst_periph;
   logic       rst_core;
   logic       ready;
   logic [7:0] lost_count;

   modport master (
      output pll_locked,
      output ext_rst,
      input  rst_periph,
      input  rst_core,
      input  ready,
      input  lost_count
   );

   modport slave (
      input  pll_locked,
      input  ext_rst,
      output rst_periph,
      output rst_core,
      output ready,
      output lost_count
   );
endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - ordered peripheral/core reset release from PLL lock and button
// Peripherals leave reset first, the core PERIPH_LEAD cycles later; lock loss is counted.
module rst_sequencer #(
   parameter int SYNC_STAGES     = 2,
   parameter int LOCK_CYCLES     = 1024,
   parameter int PERIPH_LEAD     = 16,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic            clk,
   input  logic            rst,
   rst_sequencer_if.slave  bus
);
   localparam int LW = (LOCK_CYCLES     > 1) ? $clog2(LOCK_CYCLES)     : 1;
   localparam int PW = (PERIPH_LEAD     > 1) ? $clog2(PERIPH_LEAD)     : 1;
   localparam int CW = (LW > PW) ? LW : PW;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {HOLD, WAIT, PERIPH, RUN} state_t;

   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic [SYNC_STAGES-1:0] r_btn_sync;
   logic                   r_btn_db;
   logic [DW-1:0]          r_cnt_db;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [7:0]             r_lost;

   state_t                 w_state_nxt;
   logic [CW-1:0]          w_cnt_nxt;
   logic [7:0]             w_lost_nxt;
   logic                   w_lock_s;
   logic                   w_btn_s;
   logic                   w_abort;

   assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
   assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];
   assign w_abort  = !w_lock_s || r_btn_db;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock_sync <= '0;
         r_btn_sync  <= '0;
         r_btn_db    <= 1'b0;
         r_cnt_db    <= '0;
      end else begin
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
         r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], bus.ext_rst};
         if (w_btn_s == r_btn_db) begin
            r_cnt_db <= '0;
         end else if (r_cnt_db == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_btn_db <= w_btn_s;
            r_cnt_db <= '0;
         end else begin
            r_cnt_db <= r_cnt_db + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HOLD;
         r_cnt   <= '0;
         r_lost  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lost  <= w_lost_nxt;
      end
   end

   // Abort is tested before counter completion so a dying lock never reaches RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lost_nxt  = r_lost;
      case (r_state)
         HOLD: begin
            if (w_lock_s && !r_btn_db) begin
               w_state_nxt = WAIT;
               w_cnt_nxt   = '0;
            end
         end
         WAIT: begin
            if (w_abort) begin
               w_state_nxt = HOLD;
            end else if (r_cnt == CW'(LOCK_CYCLES - 1)) begin
               w_state_nxt = PERIPH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         PERIPH: begin
            if (w_abort) begin
               w_state_nxt = HOLD;
            end else if (r_cnt == CW'(PERIPH_LEAD - 1)) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RUN: begin
            if (w_abort) begin
               w_state_nxt = HOLD;
            end
         end
         default: w_state_nxt = HOLD;
      endcase
      if ((r_state == PERIPH || r_state == RUN) && !w_lock_s && r_lost != 8'hFF) begin
         w_lost_nxt = r_lost + 8'd1;
      end
   end

   assign bus.rst_periph = (r_state == HOLD) || (r_state == WAIT);
   assign bus.rst_core   = (r_state != RUN);
   assign bus.ready      = (r_state == RUN);
   assign bus.lost_count = r_lost;
endmodule
